// File: rtl/qgen_pkg.sv
// -----------------------------------------------------------------------------
// qgen_pkg
// Shared types and helpers for the quadrature generator.
//   phase_t      : quadrature phase, encoded in cw order so that a cw step is
//                  phase + 1 and a ccw step is phase - 1 (both mod 4).
//   state_t      : edge scheduler state (IDLE / HOLD).
//   DETENT_STEPS : number of edges in one mechanical detent.
//   REQ_STEPS    : edges queued per cw/ccw request. This is DETENT_STEPS when
//                  QGEN_DETENT_EN is defined and 1 otherwise.
// Configuration macro: QGEN_DETENT_EN.
// -----------------------------------------------------------------------------
package qgen_pkg;

  typedef enum logic [1:0] {
    P00 = 2'd0,
    P10 = 2'd1,
    P11 = 2'd2,
    P01 = 2'd3
  } phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DETENT_STEPS = 4;

`ifdef QGEN_DETENT_EN
  localparam int REQ_STEPS = DETENT_STEPS;
`else
  localparam int REQ_STEPS = 1;
`endif

  // One quadrature step; the 2-bit wrap provides the mod-4 behaviour.
  function automatic phase_t phase_step(input phase_t p, input logic ccw_dir);
    return ccw_dir ? phase_t'(p - 2'd1) : phase_t'(p + 2'd1);
  endfunction

  function automatic logic phase_a(input phase_t p);
    return (p == P10) || (p == P11);
  endfunction

  function automatic logic phase_b(input phase_t p);
    return (p == P11) || (p == P01);
  endfunction

endpackage

// File: rtl/quadrature_gen_if.sv
// -----------------------------------------------------------------------------
// quadrature_gen_if
// Bundle carrying step requests into the generator and quadrature and status
// signals out of it.
//   cw, ccw : one-cycle step requests (control logic -> generator)
//   a, b    : quadrature channels (generator -> encoder input / board pins)
//   busy    : generator has queued steps or is timing an edge gap
//   ovf     : sticky flag for a request dropped on saturation
// modport master : control side that issues requests.
// modport slave  : generator side.
// -----------------------------------------------------------------------------
interface quadrature_gen_if;
  logic cw;
  logic ccw;
  logic a;
  logic b;
  logic busy;
  logic ovf;

  modport master (output cw, output ccw, input a, input b, input busy, input ovf);
  modport slave  (input cw, input ccw, output a, output b, output busy, output ovf);
endinterface

// File: rtl/qgen_rate_timer.sv
// -----------------------------------------------------------------------------
// qgen_rate_timer
// Loadable down-counter that enforces the minimum gap between quadrature
// edges. A load sets the count to STEP_CYCLES-1. The counter then decrements
// once per cycle until it reaches zero and holds there.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (count = 0)
//   i_load  : reload the counter (an edge is emitted on this clock)
//   o_zero  : counter is at zero, so the gap has elapsed
// -----------------------------------------------------------------------------
module qgen_rate_timer #(
  parameter int STEP_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_zero
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only. All
  // flops then sample their inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/quadrature_gen.sv
// -----------------------------------------------------------------------------
// quadrature_gen
// Quadrature signal generator. One-cycle cw/ccw requests are queued in a
// signed pending count. The count is replayed as a/b quadrature edges with at
// least STEP_CYCLES clocks between consecutive edges.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : quadrature_gen_if.slave carrying cw, ccw (in) and
//              a, b, busy, ovf (out)
// Parameters:
//   STEP_CYCLES : minimum clocks between a/b edges (>= 2)
//   PEND_W      : width of the signed pending-step counter
// Configuration macro: QGEN_DETENT_EN. When defined, each request queues a full
// detent of 4 edges.
// -----------------------------------------------------------------------------
module quadrature_gen
  import qgen_pkg::*;
#(
  parameter int STEP_CYCLES = 5000,
  parameter int PEND_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  quadrature_gen_if.slave  bus
);

  // Net arithmetic runs two bits wider, so pending + request cannot wrap
  // before the saturation test.
  localparam int NW = PEND_W + 2;
  // The limit is symmetric and rounded down to a whole number of requests.
  // This makes a request that does not fit get dropped whole.
  localparam int LIMIT_I = (((2 ** (PEND_W - 1)) - 1) / REQ_STEPS) * REQ_STEPS;
  localparam logic signed [NW-1:0] LIMIT   = NW'(LIMIT_I);
  localparam logic signed [NW-1:0] REQ_AMT = NW'(REQ_STEPS);
  localparam logic signed [NW-1:0] ONE     = NW'(1);

  logic signed [PEND_W-1:0] r_pending;
  state_t                   r_state;
  logic                     r_a;
  logic                     r_b;
  logic                     r_ovf;

  logic                     w_timer_zero;
  logic                     w_emit;
  logic                     w_emit_ccw;
  logic                     w_drop;
  logic signed [NW-1:0]     w_req;
  logic signed [NW-1:0]     w_after_emit;
  logic signed [NW-1:0]     w_net;
  logic signed [PEND_W-1:0] w_pending_next;
  state_t                   w_state_next;
  phase_t                   w_phase;
  phase_t                   w_phase_next;

  // a and b are the registered outputs themselves. The phase is decoded back
  // from them, so the pins are driven straight from flops and cannot glitch.
  assign w_phase = phase_t'({r_b, r_a ^ r_b});

  // An edge may go out from IDLE right away. From HOLD it must wait until the
  // spacing timer has run out.
  assign w_emit     = (r_pending != '0) && ((r_state == IDLE) || w_timer_zero);
  assign w_emit_ccw = r_pending[PEND_W-1];

  always_comb begin
    // NOTE: every signal gets a default before the conditional logic. This
    // keeps always_comb free of inferred latches.
    w_req          = '0;
    w_after_emit   = NW'(r_pending);
    w_net          = '0;
    w_drop         = 1'b0;
    w_pending_next = r_pending;

    if (bus.cw && !bus.ccw) begin
      w_req = REQ_AMT;
    end else if (bus.ccw && !bus.cw) begin
      w_req = -REQ_AMT;
    end

    // The emitted edge moves pending one step toward zero.
    if (w_emit) begin
      w_after_emit = w_emit_ccw ? (w_after_emit + ONE) : (w_after_emit - ONE);
    end

    // Saturation is judged on the net value after this cycle's emission. A
    // request that would overflow is dropped, but the emission still counts.
    w_net  = w_after_emit + w_req;
    w_drop = (w_req != '0) && ((w_net > LIMIT) || (w_net < -LIMIT));
    w_pending_next = w_drop ? PEND_W'(w_after_emit) : PEND_W'(w_net);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_emit) w_state_next = HOLD;
      HOLD: if (w_timer_zero && !w_emit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_phase_next = w_emit ? phase_step(w_phase, w_emit_ccw) : w_phase;

  qgen_rate_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_rate_timer (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_emit),
    .o_zero (w_timer_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_state   <= IDLE;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_state   <= w_state_next;
      r_a       <= phase_a(w_phase_next);
      r_b       <= phase_b(w_phase_next);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.a    = r_a;
  assign bus.b    = r_b;
  assign bus.ovf  = r_ovf;
  assign bus.busy = (r_pending != '0) || (r_state == HOLD);

endmodule

// File: tb/tb_quadrature_gen.sv
// -----------------------------------------------------------------------------
// tb_quadrature_gen
// Self-checking bench for quadrature_gen with STEP_CYCLES=4 and PEND_W=4.
// The reference model tracks an integer pending count, an integer phase and
// the number of clocks since the last edge. An edge is allowed once that
// elapsed time reaches STEP_CYCLES. A small loopback decoder counts the cw and
// ccw edges on a/b and checks the spacing between them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_quadrature_gen;

  localparam int STEP_CYCLES = 4;
  localparam int PEND_W      = 4;
`ifdef QGEN_DETENT_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif
  localparam int LIM = (((1 << (PEND_W - 1)) - 1) / K) * K;

  logic clk;
  logic reset_n;

  quadrature_gen_if bus ();

  quadrature_gen #(
    .STEP_CYCLES (STEP_CYCLES),
    .PEND_W      (PEND_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pend;
  int m_ph;        // 0:(a,b)=00 1:10 2:11 3:01
  int m_since;     // clocks since the last emitted edge (saturating)
  bit m_ovf;
  int m_accepted;  // net edges accepted into the queue since the last clear

  // ---------------- loopback decoder ----------------
  logic [1:0] d_prev;
  int d_cw, d_ccw, d_bad;
  int cyc, last_edge;

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] exp_vec();
    logic ea, eb, ebusy;
    ea    = (m_ph == 1) || (m_ph == 2);
    eb    = (m_ph >= 2);
    ebusy = (m_pend != 0) || (m_since < STEP_CYCLES);
    return {ea, eb, ebusy, m_ovf};
  endfunction

  task automatic model_reset();
    m_pend    = 0;
    m_ph      = 0;
    m_since   = STEP_CYCLES;
    m_ovf     = 1'b0;
    d_prev    = 2'b00;
    last_edge = -1;
  endtask

  task automatic model_step(input bit c, input bit cc);
    int req, dir, net;
    req = (c && !cc) ? K : ((cc && !c) ? -K : 0);
    dir = 0;
    if (m_since < STEP_CYCLES) m_since++;
    if (m_pend != 0 && m_since >= STEP_CYCLES) begin
      dir     = (m_pend > 0) ? 1 : -1;
      m_ph    = (m_ph + dir + 4) % 4;
      m_since = 0;
    end
    net = m_pend - dir + req;
    if (req != 0 && (net > LIM || net < -LIM)) begin
      m_ovf = 1'b1;
      net   = m_pend - dir;
    end else begin
      m_accepted += req;
    end
    m_pend = net;
  endtask

  task automatic observe();
    logic [1:0] cur;
    int dlt;
    cur = {bus.a, bus.b};
    if (cur !== d_prev) begin
      dlt = (ph_of(cur) - ph_of(d_prev) + 4) % 4;
      if (dlt == 1) d_cw++;
      else if (dlt == 3) d_ccw++;
      else d_bad++;
      if (last_edge >= 0)
        check($sformatf("spacing@%0d", cyc), 32'(cyc - last_edge >= STEP_CYCLES), 32'd1);
      last_edge = cyc;
      d_prev    = cur;
    end
  endtask

  // Called at a negedge. Drives requests for one cycle, advances the model at
  // the posedge and compares the outputs 1 ns later.
  task automatic do_cycle(input bit c, input bit cc);
    bus.cw  = c;
    bus.ccw = cc;
    @(posedge clk);
    model_step(c, cc);
    #1;
    cyc++;
    check($sformatf("out@%0d", cyc), 32'({bus.a, bus.b, bus.busy, bus.ovf}), 32'(exp_vec()));
    observe();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    d_cw = 0; d_ccw = 0; m_accepted = 0;
  endtask

  // Asserts reset between clock edges and checks that it acts at once.
  task automatic apply_reset(input string tag);
    bus.cw  = 1'b0;
    bus.ccw = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check(tag, 32'({bus.a, bus.b, bus.busy, bus.ovf}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cw  = 1'b0;
    bus.ccw = 1'b0;
    cyc     = 0;
    d_bad   = 0;
    clear_counts();
    model_reset();
    #1;
    check("reset_state", 32'({bus.a, bus.b, bus.busy, bus.ovf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single cw: a/b changes after the second clock edge.
    clear_counts();
    do_cycle(1'b1, 1'b0);
    check("lat_edge1", 32'({bus.a, bus.b}), 32'b00);
    do_cycle(1'b0, 1'b0);
    check("lat_edge2", 32'({bus.a, bus.b}), 32'b10);
    idle(20);
    check("single_cw", 32'(d_cw), 32'(m_accepted));
    check("single_ccw", 32'(d_ccw), 32'd0);

    // Five back-to-back cw.
    clear_counts();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0);
    idle(30);
    check("five_cw", 32'(d_cw), 32'(m_accepted));
    check("five_ccw", 32'(d_ccw), 32'd0);

    // cw, cw, ccw, ccw, ccw: net -1 request.
    clear_counts();
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b0, 1'b1);
    idle(30);
    check("mixed_net", 32'(d_cw - d_ccw), 32'(m_accepted));

    // Simultaneous cw+ccw cancel.
    clear_counts();
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1);
    check("cancel_edges", 32'(d_cw + d_ccw), 32'd0);
    check("cancel_ovf", 32'(bus.ovf), 32'd0);

    // Single ccw (a full reverse detent when detents are enabled).
    clear_counts();
    do_cycle(1'b0, 1'b1);
    idle(24);
    check("ccw_edges", 32'(d_ccw), 32'(-m_accepted));
    check("ccw_cw", 32'(d_cw), 32'd0);

    // Saturation: a cw burst well past the limit.
    clear_counts();
    for (int i = 0; i < 14; i++) do_cycle(1'b1, 1'b0);
    check("sat_ovf", 32'(bus.ovf), 32'd1);
    idle(70);
    check("sat_edges", 32'(d_cw), 32'(m_accepted));
    check("sat_ccw", 32'(d_ccw), 32'd0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    apply_reset("midburst_reset");
    idle(4);

    // Randomized traffic, dense and then sparse, each followed by a drain.
    for (int phase = 0; phase < 2; phase++) begin
      clear_counts();
      for (int i = 0; i < 400; i++) begin
        int r;
        r = $urandom_range(0, (phase == 0) ? 7 : 31);
        do_cycle(r == 0 || r == 2, r == 1 || r == 2);
      end
      idle(80);
      check($sformatf("rand_net%0d", phase), 32'(d_cw - d_ccw), 32'(m_accepted));
      check($sformatf("rand_idle%0d", phase), 32'(bus.busy), 32'd0);
    end

    check("illegal_edges", 32'(d_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
